// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Issue/capture stage around a combinational ALU. It registers
//               the operands, waits for the ALU to settle and then holds the
//               result until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int ARITH_WAIT  = 1,
    parameter int MULDIV_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_opcode,
    input  logic        in_mode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_mode,
    input  logic [63:0] alu_out,
    input  logic [4:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic [4:0]  res_flags,
    output logic        res_err,
    output logic        busy
);

    localparam int                 c_CNT_W       = $clog2(MULDIV_WAIT + ARITH_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_ARITH_LOAD  = c_CNT_W'(ARITH_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_MULDIV_LOAD = c_CNT_W'(MULDIV_WAIT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state_q,      w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,        w_cnt_d;
    logic [31:0]        r_alu_a_q,      w_alu_a_d;
    logic [31:0]        r_alu_b_q,      w_alu_b_d;
    logic [2:0]         r_alu_opcode_q, w_alu_opcode_d;
    logic               r_alu_mode_q,   w_alu_mode_d;
    logic [63:0]        r_res_data_q,   w_res_data_d;
    logic [4:0]         r_res_flags_q,  w_res_flags_d;
    logic               r_res_err_q,    w_res_err_d;

    logic w_is_muldiv;
    logic w_is_err;

    assign w_is_muldiv = !in_mode && ((in_opcode == 3'b001) || (in_opcode == 3'b011));
    // Opcodes 1xx in arithmetic mode are undefined; divide-by-zero is trapped too.
    assign w_is_err    = !in_mode && (in_opcode[2] || ((in_opcode == 3'b011) && (in_b == '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= c_ST_IDLE;
            r_cnt_q        <= '0;
            r_alu_a_q      <= '0;
            r_alu_b_q      <= '0;
            r_alu_opcode_q <= '0;
            r_alu_mode_q   <= 1'b0;
            r_res_data_q   <= '0;
            r_res_flags_q  <= '0;
            r_res_err_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_alu_a_q      <= w_alu_a_d;
            r_alu_b_q      <= w_alu_b_d;
            r_alu_opcode_q <= w_alu_opcode_d;
            r_alu_mode_q   <= w_alu_mode_d;
            r_res_data_q   <= w_res_data_d;
            r_res_flags_q  <= w_res_flags_d;
            r_res_err_q    <= w_res_err_d;
        end
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_alu_a_d      = r_alu_a_q;
        w_alu_b_d      = r_alu_b_q;
        w_alu_opcode_d = r_alu_opcode_q;
        w_alu_mode_d   = r_alu_mode_q;
        w_res_data_d   = r_res_data_q;
        w_res_flags_d  = r_res_flags_q;
        w_res_err_d    = r_res_err_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_alu_a_d      = in_a;
                    w_alu_b_d      = in_b;
                    w_alu_opcode_d = in_opcode;
                    w_alu_mode_d   = in_mode;
                    if (w_is_err) begin
                        w_res_data_d  = '0;
                        w_res_flags_d = '0;
                        w_res_err_d   = 1'b1;
                        w_state_d     = c_ST_DONE;
                    end else begin
                        w_cnt_d     = w_is_muldiv ? c_MULDIV_LOAD : c_ARITH_LOAD;
                        w_res_err_d = 1'b0;
                        w_state_d   = c_ST_EXEC;
                    end
                end
            end
            c_ST_EXEC: begin
                if (r_cnt_q == '0) begin
                    w_res_data_d  = alu_out;
                    w_res_flags_d = alu_flags;
                    w_state_d     = c_ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end
            end
            c_ST_DONE: begin
                if (res_ready) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state_q == c_ST_IDLE);
        res_valid = (r_state_q == c_ST_DONE);
        busy      = (r_state_q != c_ST_IDLE);
    end

    assign alu_a      = r_alu_a_q;
    assign alu_b      = r_alu_b_q;
    assign alu_opcode = r_alu_opcode_q;
    assign alu_mode   = r_alu_mode_q;
    assign res_data   = r_res_data_q;
    assign res_flags  = r_res_flags_q;
    assign res_err    = r_res_err_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Issue/capture stage wrapped around the combinational ALU (a, b, opcode, mode -> outALU[63:0], za, zb, eq, gt, lt).
- Accepts one operation at a time over a valid/ready handshake and registers the operands that drive the ALU.
- Waits an opcode-dependent number of settle cycles, then captures outALU and the flags into result registers, which are held for the downstream consumer (register-file writeback) until it accepts them.
- Traps divide-by-zero and undefined arithmetic opcodes without capturing the ALU result.

Parameters:
- ARITH_WAIT, 1, settle cycles for add/sub and all mode=1 ops; must be >=1.
- MULDIV_WAIT, 3, settle cycles for mode=0 opcode 001 (mul) and 011 (div); must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  stage can accept a request.
- in_a  input  32  operand A.
- in_b  input  32  operand B.
- in_opcode  input  3  ALU opcode.
- in_mode  input  1  0 = arithmetic, 1 = logic/compare.
- alu_a  output  32  registered operand to ALU a.
- alu_b  output  32  registered operand to ALU b.
- alu_opcode  output  3  registered opcode to ALU.
- alu_mode  output  1  registered mode to ALU.
- alu_out  input  64  ALU outALU.
- alu_flags  input  5  ALU flags {za,zb,eq,gt,lt}.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts the result.
- res_data  output  64  captured result.
- res_flags  output  5  captured {za,zb,eq,gt,lt}.
- res_err  output  1  1 = div-by-zero or illegal opcode.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - alu_a, alu_b, alu_opcode, alu_mode, res_data, res_flags, res_err, res_valid and the wait counter all go to 0.
  - in_ready=1 and busy=0 once reset is released.
- States: IDLE, EXEC, DONE.
  - in_ready=1 only in IDLE.
  - res_valid=1 only in DONE.
- IDLE:
  - On a clk edge with in_valid=1, latch in_a/in_b/in_opcode/in_mode into the alu_* registers.
  - Wait selection: W=MULDIV_WAIT if mode=0 and opcode is 001 or 011, else W=ARITH_WAIT.
  - Error case: if (mode=0, opcode=011, in_b==0) or (mode=0, in_opcode[2]=1), go straight to DONE with res_data=0, res_flags=0, res_err=1.
  - Otherwise load counter=W-1, clear res_err, and go to EXEC.
- EXEC:
  - The counter decrements each edge.
  - On the edge where counter==0, capture alu_out into res_data and alu_flags into res_flags, then go to DONE.
  - Accept at edge k gives capture at edge k+W; res_valid is high from edge k+W.
  - The alu_* registers stay stable for the whole of EXEC and DONE.
- DONE:
  - res_valid, res_data, res_flags and res_err are held stable while res_ready=0.
  - On an edge with res_ready=1, go to IDLE; res_valid drops that edge.
  - in_valid is ignored in DONE. No same-cycle re-accept: the next accept is earliest one cycle after the hand-off.
- alu_* registers keep the last operation's values after returning to IDLE; they change only on a new accept.
- res_data/res_flags/res_err keep their last values outside DONE; only res_valid qualifies them.
- Counter width is $clog2(MULDIV_WAIT+ARITH_WAIT+1); it never wraps.
- Reset during EXEC or DONE aborts immediately: all outputs return to reset values and the pending result is discarded.
- in_* inputs are don't-care when not accepted; held in_valid with changing data is sampled only at the accept edge.

Test Plan:
- Add 5+3 (mode0, op000), ARITH_WAIT=1, res_ready=1: accept at edge 0 -> alu_a=5, alu_b=3 after edge 0; res_valid=1 after edge 1 with res_data=64'h8, res_err=0; IDLE after edge 2.
- Mul 2*4 (op001), MULDIV_WAIT=3: res_valid rises exactly 3 edges after accept, res_data=64'h8; in_ready=0 and busy=1 for the whole interval.
- Div 8/0 (mode0, op011, b=0): res_valid 1 edge after accept with res_data=0, res_flags=0, res_err=1; alu_a=8, alu_b=0 still driven. Then mode0 op101 -> same error response.
- Backpressure on AND FFFFFFFF & 0000FFFF (mode1, op000): hold res_ready=0 for 5 cycles -> res_valid, res_data=64'h0000FFFF and flags stable, in_ready=0, a pulsing in_valid is ignored; raise res_ready -> IDLE next edge, in_ready=1.
- Async reset: assert rst_n=0 mid-EXEC of a div 8/2 -> all outputs 0 immediately, no res_valid after release; a new add 1+1 then completes normally with res_data=2.
- Back-to-back: issue add, sub 7-2, and compare 5==5 with res_ready tied high -> three results 8, 5 and the ALU compare output, each with its captured flags, in order, spaced by at least W+2 cycles.
